// File: rtl/reset_ctrl.sv
// Reset-key front end: sync + debounce of btn_n, stretched sys_rst_n request, and clk14 enable divider.
// sys_rst_n/press lag btn_n by DEBOUNCE_CYC+2 edges; there is no backpressure and ce runs free.
module reset_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 14000,
  parameter int unsigned MIN_PULSE    = 64,
  parameter int unsigned CE_DIV       = 14
) (
  input  logic clk14,
  input  logic rst_n,
  input  logic btn_n,
  output logic ce,
  output logic sys_rst_n,
  output logic press
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]  PULSE_LAST = 8'(MIN_PULSE - 1);
  localparam logic [7:0]  CE_LAST    = 8'(CE_DIV - 1);

  logic        r_s1;
  logic        r_s2;
  logic        r_db_state;
  logic [15:0] r_db_cnt;
  logic [7:0]  r_pulse_cnt;
  logic [7:0]  r_ce_cnt;
  logic [1:0]  r_state;
  logic        r_ce;
  logic        r_sys_rst_n;
  logic        r_press;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= btn_n;
      r_s2 <= r_s1;
    end
  end

  // A new level must persist DEBOUNCE_CYC consecutive samples; any bounce back restarts the count.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      r_db_state <= 1'b1;
      r_db_cnt   <= '0;
    end else if (r_s2 == r_db_state) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_state <= r_s2;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 16'd1;
    end
  end

  // Reset lands in ASSERT so power-up also yields a full minimum-width pulse, without a press.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ASSERT;
      r_pulse_cnt <= '0;
      r_sys_rst_n <= 1'b0;
      r_press     <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sys_rst_n <= 1'b1;
          if (!r_db_state) begin
            r_state     <= ST_ASSERT;
            r_pulse_cnt <= '0;
            r_sys_rst_n <= 1'b0;
            r_press     <= 1'b1;
          end
        end
        ST_ASSERT: begin
          r_sys_rst_n <= 1'b0;
          r_pulse_cnt <= r_pulse_cnt + 8'd1;
          if (r_pulse_cnt == PULSE_LAST) begin
            if (r_db_state) begin
              r_state     <= ST_IDLE;
              r_sys_rst_n <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_sys_rst_n <= 1'b0;
          if (r_db_state) begin
            r_state     <= ST_IDLE;
            r_sys_rst_n <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_sys_rst_n <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      r_ce_cnt <= '0;
      r_ce     <= 1'b0;
    end else if (r_ce_cnt == CE_LAST) begin
      r_ce_cnt <= '0;
      r_ce     <= 1'b1;
    end else begin
      r_ce_cnt <= r_ce_cnt + 8'd1;
      r_ce     <= 1'b0;
    end
  end

  assign ce        = r_ce;
  assign sys_rst_n = r_sys_rst_n;
  assign press     = r_press;

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: directed phases plus random key bouncing against an edge-indexed reference model.
module tb_reset_ctrl;

  localparam int DB  = 4;
  localparam int MP  = 8;
  localparam int CD  = 14;
  localparam int HMAX = 8192;

  logic clk14 = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;
  logic ce, sys_rst_n, press;
  logic ce2, sys_rst_n2, press2;

  int checks = 0;
  int errors = 0;

  // Model state: k = edges since reset release, hist[j] = btn_n level sampled at edge j.
  int  k;
  bit  hist [0:HMAX-1];
  bit  m_db, m_sys, m_press, m_ce, m_ce2;
  int  m_start;
  int  n_press;

  reset_ctrl #(.DEBOUNCE_CYC(DB), .MIN_PULSE(MP), .CE_DIV(CD)) dut (
    .clk14(clk14), .rst_n(rst_n), .btn_n(btn_n),
    .ce(ce), .sys_rst_n(sys_rst_n), .press(press)
  );

  reset_ctrl #(.DEBOUNCE_CYC(DB), .MIN_PULSE(MP), .CE_DIV(2)) dut2 (
    .clk14(clk14), .rst_n(rst_n), .btn_n(btn_n),
    .ce(ce2), .sys_rst_n(sys_rst_n2), .press(press2)
  );

  always #5 clk14 = ~clk14;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  function automatic bit samp(input int j);
    return (j <= 0) ? 1'b1 : hist[j];
  endfunction

  task automatic model_reset();
    k = 0; m_db = 1'b1; m_sys = 1'b0; m_press = 1'b0; m_start = 0;
    m_ce = 1'b0; m_ce2 = 1'b0;
    for (int i = 0; i < HMAX; i++) hist[i] = 1'b1;
  endtask

  // Advance one edge; the synchroniser delivers the level sampled two edges earlier to the debouncer.
  task automatic step();
    bit flip;
    @(posedge clk14);
    k++;
    if (k >= HMAX) begin
      $display("FAIL history overflow at edge %0d", k);
      $fatal(1, "history overflow");
    end
    hist[k] = btn_n;
    m_press = 1'b0;
    if (m_sys) begin
      if (!m_db) begin
        m_sys = 1'b0; m_press = 1'b1; m_start = k; n_press++;
      end
    end else if ((k - m_start) >= MP && m_db) begin
      m_sys = 1'b1;
    end
    flip = 1'b1;
    for (int i = k - DB - 1; i <= k - 2; i++)
      if (samp(i) == m_db) flip = 1'b0;
    if (flip) m_db = ~m_db;
    m_ce  = (k % CD) == 0;
    m_ce2 = (k % 2) == 0;
    #1;
    check("sys_rst_n", sys_rst_n, m_sys);
    check("press", press, m_press);
    check("ce", ce, m_ce);
    check("ce_div2", ce2, m_ce2);
    check("sys_rst_n_div2", sys_rst_n2, m_sys);
  endtask

  task automatic hold(input logic lvl, input int n);
    btn_n = lvl;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int p0;
    model_reset();
    n_press = 0;
    repeat (3) @(posedge clk14);
    #1;
    check("reset_ce", ce, 1'b0);
    check("reset_sys_rst_n", sys_rst_n, 1'b0);
    check("reset_press", press, 1'b0);
    rst_n = 1'b1;

    // Power-on pulse and ce cadence with the key idle
    hold(1'b1, 45);
    check("poweron_no_press", (n_press == 0), 1'b1);

    // Short glitch and fast bounce must both be filtered
    hold(1'b0, 3);
    hold(1'b1, 10);
    for (int i = 0; i < 20; i++) hold(logic'(i % 2 == 0 ? 0 : 1), 1);
    hold(1'b1, 10);
    check("glitch_no_press", (n_press == 0), 1'b1);

    // Tap released before the pulse ends, then a long hold
    p0 = n_press;
    hold(1'b0, 6);
    hold(1'b1, 20);
    hold(1'b0, 60);
    hold(1'b1, 20);
    check("two_presses", (n_press == p0 + 2), 1'b1);

    // Random bouncy key activity
    for (int s = 0; s < 60; s++)
      hold(logic'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
    hold(1'b1, 20);

    // Async reset in the middle of a held press
    hold(1'b0, 10);
    #3 rst_n = 1'b0;
    #1;
    check("async_sys_rst_n", sys_rst_n, 1'b0);
    check("async_press", press, 1'b0);
    check("async_ce", ce, 1'b0);
    check("async_ce_div2", ce2, 1'b0);
    repeat (2) @(posedge clk14);
    #1;
    check("held_reset_sys_rst_n", sys_rst_n, 1'b0);
    model_reset();
    p0 = n_press;
    rst_n = 1'b1;
    hold(1'b0, 30);
    check("post_reset_still_low", sys_rst_n, 1'b0);
    hold(1'b1, 20);
    check("post_reset_no_press", (n_press == p0), 1'b1);
    check("post_reset_released", sys_rst_n, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
